// File: rtl/ttl_in_timestamper_pkg.sv
// Shared types for the TTL input timestamper.
// Event word layout and the helper that packs it.
package ttl_in_pkg;

    localparam int TS_W     = 64;
    localparam int RSV_W    = 48;
    localparam int EDGE_W   = 8;
    localparam int EVT_W    = 128;
    localparam int RISE_LSB = 0;
    localparam int FALL_LSB = 8;
    localparam int RSV_LSB  = 16;
    localparam int TS_LSB   = 64;

    typedef struct packed {
        logic [TS_W-1:0]   timestamp;
        logic [RSV_W-1:0]  reserved;
        logic [EDGE_W-1:0] fall;
        logic [EDGE_W-1:0] rise;
    } ttl_event_t;

    function automatic ttl_event_t build_event(
        input logic [TS_W-1:0]   counter,
        input logic [EDGE_W-1:0] rise,
        input logic [EDGE_W-1:0] fall
    );
        logic [EVT_W-1:0] w;
        w = '0;
        w[TS_LSB +: TS_W]     = counter;
        w[RSV_LSB +: RSV_W]   = '0;
        w[FALL_LSB +: EDGE_W] = fall;
        w[RISE_LSB +: EDGE_W] = rise;
        return ttl_event_t'(w);
    endfunction

endpackage

// File: rtl/ttl_in_timestamper_if.sv
// Read-side bundle of the timestamper event FIFO.
// master = timestamper, slave = the reader draining events.
interface ttl_in_timestamper_if #(
    parameter int ADDR_LEN = 10,
    parameter int DATA_W   = 128
);
    logic              rd_en;
    logic [DATA_W-1:0] fifo_dout;
    logic              empty;
    logic              full;
    logic [ADDR_LEN:0] occupancy;
    logic              overflow_error;
    logic [15:0]       overflow_count;

    modport master (
        input  rd_en,
        output fifo_dout, empty, full, occupancy,
        output overflow_error, overflow_count
    );

    modport slave (
        output rd_en,
        input  fifo_dout, empty, full, occupancy,
        input  overflow_error, overflow_count
    );
endinterface

// File: rtl/ttl_in_timestamper_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head.
// Flush wins over push and pop; a push onto a full FIFO is dropped unless a pop frees a slot.
module ttl_in_fifo
    import ttl_in_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LEN = 10,
    parameter int WIDTH    = EVT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    input  logic              flush,
    output logic [WIDTH-1:0]  dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_LEN:0] occupancy,
    output logic              dropped
);

    localparam logic [ADDR_LEN:0]   CNT_MAX = (ADDR_LEN+1)'(DEPTH);
    localparam logic [ADDR_LEN-1:0] PTR_MAX = ADDR_LEN'(DEPTH - 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_LEN-1:0] wr_ptr;
    logic [ADDR_LEN-1:0] rd_ptr;
    logic [ADDR_LEN-1:0] wr_nxt;
    logic [ADDR_LEN-1:0] rd_nxt;
    logic [ADDR_LEN:0]   count;
    logic [WIDTH-1:0]    head_nxt;
    logic                pop_ok;
    logic                push_ok;

    assign pop_ok  = pop & (count != '0) & ~flush;
    assign push_ok = push & ~flush & ((count != CNT_MAX) | pop_ok);
    assign dropped = push & ~flush & ~push_ok;

    assign wr_nxt = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt = (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;

    // The head register must already hold the next entry when the pop retires.
    always_comb begin
        head_nxt = dout;
        if (pop_ok) begin
            if (count > (ADDR_LEN+1)'(1)) head_nxt = mem[rd_nxt];
            else if (push_ok)             head_nxt = wdata;
        end else if (count == '0 && push_ok) begin
            head_nxt = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_nxt;
            if (pop_ok)  rd_ptr <= rd_nxt;
            count <= count + (ADDR_LEN+1)'(push_ok) - (ADDR_LEN+1)'(pop_ok);
            dout  <= head_nxt;
        end
    end

    assign empty     = (count == '0);
    assign full      = (count == CNT_MAX);
    assign occupancy = count;

endmodule

// File: rtl/ttl_in_timestamper.sv
// TTL input timestamper: synchronizes inputs, detects masked edges and
// queues timestamped event words for the read side.
module ttl_in_timestamper
    import ttl_in_pkg::*;
#(
    parameter int CHANNEL_NUM     = 8,
    parameter int DEPTH           = 1024,
    parameter int ADDR_LEN        = 10,
    parameter int COUNTER_WIDTH   = 64,
    parameter int FIFO_DATA_WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNEL_NUM-1:0]   input_pulse,
    input  logic [COUNTER_WIDTH-1:0] counter,
    input  logic                     capture_en,
    input  logic [CHANNEL_NUM-1:0]   rise_mask,
    input  logic [CHANNEL_NUM-1:0]   fall_mask,
    input  logic                     flush,
    ttl_in_timestamper_if.master     rd
);

    logic [CHANNEL_NUM-1:0]     s1;
    logic [CHANNEL_NUM-1:0]     s2;
    logic [CHANNEL_NUM-1:0]     prev;
    logic [EDGE_W-1:0]          rise;
    logic [EDGE_W-1:0]          fall;
    logic                       push;
    logic                       dropped;
    ttl_event_t                 evt;
    logic [FIFO_DATA_WIDTH-1:0] wdata;
    logic                       ovf_err;
    logic [15:0]                ovf_cnt;

    // Runs regardless of capture_en so enabling capture never sees a stale level.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= input_pulse;
            s2   <= s1;
            prev <= s2;
        end
    end

    always_comb begin
        rise = '0;
        fall = '0;
        rise[CHANNEL_NUM-1:0] = s2 & ~prev & rise_mask;
        fall[CHANNEL_NUM-1:0] = ~s2 & prev & fall_mask;
    end

    assign push  = capture_en & ((|rise) | (|fall));
    assign evt   = build_event(TS_W'(counter), rise, fall);
    assign wdata = FIFO_DATA_WIDTH'(evt);

    ttl_in_fifo #(
        .DEPTH    (DEPTH),
        .ADDR_LEN (ADDR_LEN),
        .WIDTH    (FIFO_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wdata     (wdata),
        .pop       (rd.rd_en),
        .flush     (flush),
        .dout      (rd.fifo_dout),
        .empty     (rd.empty),
        .full      (rd.full),
        .occupancy (rd.occupancy),
        .dropped   (dropped)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ovf_err <= 1'b0;
            ovf_cnt <= '0;
        end else if (dropped) begin
            ovf_err <= 1'b1;
            if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign rd.overflow_error = ovf_err;
    assign rd.overflow_count = ovf_cnt;

endmodule

// File: tb/tb_ttl_in_timestamper.sv
// Randomized bench for ttl_in_timestamper against a queue-based event model.
// Small FIFO so overflow, wrap and flush paths are exercised often.
module tb_ttl_in_timestamper;
    import ttl_in_pkg::*;

    localparam int CH    = 8;
    localparam int DEPTH = 4;
    localparam int AL    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] input_pulse;
    logic [63:0]   counter;
    logic          capture_en;
    logic [CH-1:0] rise_mask;
    logic [CH-1:0] fall_mask;
    logic          flush;

    int n_vec = 0;
    int n_err = 0;

    ttl_in_timestamper_if #(.ADDR_LEN(AL), .DATA_W(128)) rd();

    ttl_in_timestamper #(
        .CHANNEL_NUM     (CH),
        .DEPTH           (DEPTH),
        .ADDR_LEN        (AL),
        .COUNTER_WIDTH   (64),
        .FIFO_DATA_WIDTH (128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_pulse (input_pulse),
        .counter     (counter),
        .capture_en  (capture_en),
        .rise_mask   (rise_mask),
        .fall_mask   (fall_mask),
        .flush       (flush),
        .rd          (rd)
    );

    always #5 clk = ~clk;

    // Reference model: an input level seen at edge k becomes an event
    // at edge k+2, compared with the level seen one edge earlier.
    logic [127:0] mq[$];
    logic [CH-1:0] seen0, seen1, seen2;
    bit            m_err;
    int unsigned   m_cnt;

    always @(posedge clk) begin
        logic [7:0] r;
        logic [7:0] f;
        bit         pop;
        bit         was_full;
        if (reset) begin
            mq.delete();
            m_err = 0;
            m_cnt = 0;
            seen0 = '0;
            seen1 = '0;
            seen2 = '0;
        end else begin
            r = seen1 & ~seen2 & rise_mask;
            f = ~seen1 & seen2 & fall_mask;
            if (flush) begin
                mq.delete();
                m_err = 0;
                m_cnt = 0;
            end else begin
                was_full = (mq.size() == DEPTH);
                pop = rd.rd_en && (mq.size() > 0);
                if (pop) void'(mq.pop_front());
                if (capture_en && ((r | f) != 0)) begin
                    if (!was_full || pop) begin
                        mq.push_back({counter, 48'h0, f, r});
                    end else begin
                        m_err = 1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
            end
            seen2 = seen1;
            seen1 = seen0;
            seen0 = input_pulse;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("empty", 128'(rd.empty), 128'(mq.size() == 0));
        chk("full", 128'(rd.full), 128'(mq.size() == DEPTH));
        chk("occupancy", 128'(rd.occupancy), 128'(mq.size()));
        chk("ovf_err", 128'(rd.overflow_error), 128'(m_err));
        chk("ovf_cnt", 128'(rd.overflow_count), 128'(m_cnt));
        if (mq.size() > 0) chk("dout", rd.fifo_dout, mq[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
        counter = counter + 64'd1;
    endtask

    initial begin
        int p_rd;
        int p_tog;
        logic [127:0] want;
        reset       = 1'b1;
        input_pulse = '0;
        counter     = '0;
        capture_en  = 1'b0;
        rise_mask   = '0;
        fall_mask   = '0;
        flush       = 1'b0;
        rd.rd_en    = 1'b0;
        repeat (3) tick();
        chk("rst_dout", rd.fifo_dout, 128'h0);

        reset      = 1'b0;
        capture_en = 1'b1;
        rise_mask  = 8'h01;
        repeat (3) tick();
        counter        = 64'd100;
        input_pulse[0] = 1'b1;
        repeat (3) tick();
        want = {64'd102, 48'h0, 8'h00, 8'h01};
        chk("t1_word", rd.fifo_dout, want);
        chk("t1_empty", 128'(rd.empty), 128'h0);
        rd.rd_en = 1'b1;
        tick();
        rd.rd_en = 1'b0;

        for (int ph = 0; ph < 12; ph++) begin
            case (ph % 4)
                0: p_rd = 0;
                1: p_rd = 30;
                2: p_rd = 60;
                default: p_rd = 95;
            endcase
            p_tog = $urandom_range(20, 80);
            rise_mask = 8'($urandom);
            fall_mask = 8'($urandom);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 99) < p_tog)
                    input_pulse = input_pulse ^ 8'($urandom);
                if ($urandom_range(0, 99) < 3) rise_mask = 8'($urandom);
                if ($urandom_range(0, 99) < 3) fall_mask = 8'($urandom);
                if ($urandom_range(0, 99) < 1) counter = 64'hFFFF_FFFF_FFFF_FFF8;
                capture_en = ($urandom_range(0, 99) < 90);
                rd.rd_en   = ($urandom_range(0, 99) < p_rd);
                flush      = ($urandom_range(0, 199) < 3);
                reset      = ($urandom_range(0, 499) < 2);
                tick();
            end
        end

        flush    = 1'b0;
        reset    = 1'b0;
        rd.rd_en = 1'b0;
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
